// File: rtl/bist_resp_checker.sv
// bist_resp_checker
// Response-analysis stage of the BIST chain. While valid is high, the 3-bit
// CUT response is compacted into a SIG_W-bit MISR. A finish pulse moves the
// checker through a one-cycle CHECK state where the signature is compared
// against GOLDEN. The registered verdict is then held in DONE. A watchdog
// on the compacted-sample count ends a run that never sees finish.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active-low
//   start      one-cycle pulse, (re)arms the checker (ignored in CHECK)
//   valid      response sample valid
//   resp[2:0]  {sync_err_d, synced_d, scan_out} from the CUT
//   finish     one-cycle end-of-test pulse
//   busy       high in RUN and CHECK
//   done       verdict valid, held until the next start or reset
//   pass_fail  1 = signature matched GOLDEN (meaningful when done=1)
//   timeout    1 = watchdog expired before finish
//   cyc_cnt    number of compacted samples in the current/last run
//
// Optional feature, macro BIST_SIG_READOUT_EN:
//   sig_shift  in DONE, rotates the signature left by one bit per cycle
//   sig_out    continuous view of the signature register (MSB-first serial
//              readout via sig_out[SIG_W-1])
module bist_resp_checker #(
  parameter int                 SIG_W   = 8,
  parameter logic [SIG_W-1:0]   POLY    = 8'h1D,
  parameter logic [SIG_W-1:0]   SEED    = 8'h00,
  parameter logic [SIG_W-1:0]   GOLDEN  = 8'hA5,
  parameter int                 CNT_W   = 15,
  parameter logic [CNT_W-1:0]   MAX_CYC = 15'd20000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             valid,
  input  logic [2:0]       resp,
  input  logic             finish,
`ifdef BIST_SIG_READOUT_EN
  input  logic             sig_shift,
  output logic [SIG_W-1:0] sig_out,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass_fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t           state;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] sig_comp;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_cur;
  logic             arm;

  // One MISR step: shift, fold the feedback taps back in when the MSB falls
  // off, and inject the response into the low bits.
  assign sig_comp = {sig[SIG_W-2:0], 1'b0}
                  ^ (sig[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-3){1'b0}}, resp};

  // Saturating increment so a very long run never wraps to a small count.
  assign cnt_inc = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Count as it will be after this edge; the watchdog looks at this so that
  // the run ends on the same edge that compacts the limiting sample.
  assign cnt_cur = valid ? cnt_inc : cyc_cnt;

  // start re-arms from every state except the single-cycle CHECK.
  assign arm = start && (state != CHECK);

`ifdef BIST_SIG_READOUT_EN
  assign sig_out = sig;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      sig       <= SEED;
      cyc_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_fail <= 1'b0;
      timeout   <= 1'b0;
    end else if (arm) begin
      state     <= RUN;
      sig       <= SEED;
      cyc_cnt   <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass_fail <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (valid) begin
            sig     <= sig_comp;
            cyc_cnt <= cnt_inc;
          end
          // finish wins over a coincident watchdog hit
          if (finish) begin
            state <= CHECK;
          end else if (cnt_cur >= MAX_CYC) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass_fail <= 1'b0;
            timeout   <= 1'b1;
          end
        end
        CHECK: begin
          state     <= DONE;
          pass_fail <= (sig == GOLDEN);
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        DONE: begin
`ifdef BIST_SIG_READOUT_EN
          // Rotation keeps the signature intact after a full SIG_W shifts.
          if (sig_shift) begin
            sig <= {sig[SIG_W-2:0], sig[SIG_W-1]};
          end
`endif
        end
        default: begin
          // IDLE: only start (handled above) has any effect
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_resp_checker.sv
// Directed testbench for bist_resp_checker. Two instances share the
// stimulus: u_a (SEED=00, GOLDEN=03, MAX_CYC=10) and
// u_b (SEED=80, GOLDEN=1D, MAX_CYC=20000). Outputs are packed as
// {busy, done, pass_fail, timeout, cyc_cnt[14:0]} for comparison.
module tb_bist_resp_checker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, valid, finish;
  logic [2:0]  resp;
  logic        a_busy, a_done, a_pass, a_to;
  logic        b_busy, b_done, b_pass, b_to;
  logic [14:0] a_cyc, b_cyc;
`ifdef BIST_SIG_READOUT_EN
  logic        sig_shift;
  logic [7:0]  a_sig, b_sig;
`endif

  int total = 0;
  int bad   = 0;

  logic [18:0] obs_a, obs_b, exp_v;
  assign obs_a = {a_busy, a_done, a_pass, a_to, a_cyc};
  assign obs_b = {b_busy, b_done, b_pass, b_to, b_cyc};

  always #5 CLK = ~CLK;

  bist_resp_checker #(
    .SIG_W(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h03),
    .CNT_W(15), .MAX_CYC(15'd10)
  ) u_a (
    .CLK(CLK), .RST(RST), .start(start), .valid(valid), .resp(resp),
    .finish(finish),
`ifdef BIST_SIG_READOUT_EN
    .sig_shift(sig_shift), .sig_out(a_sig),
`endif
    .busy(a_busy), .done(a_done), .pass_fail(a_pass), .timeout(a_to),
    .cyc_cnt(a_cyc)
  );

  bist_resp_checker #(
    .SIG_W(8), .POLY(8'h1D), .SEED(8'h80), .GOLDEN(8'h1D),
    .CNT_W(15), .MAX_CYC(15'd20000)
  ) u_b (
    .CLK(CLK), .RST(RST), .start(start), .valid(valid), .resp(resp),
    .finish(finish),
`ifdef BIST_SIG_READOUT_EN
    .sig_shift(sig_shift), .sig_out(b_sig),
`endif
    .busy(b_busy), .done(b_done), .pass_fail(b_pass), .timeout(b_to),
    .cyc_cnt(b_cyc)
  );

  function automatic logic [18:0] pk(input logic b, input logic d,
                                     input logic p, input logic t,
                                     input logic [14:0] c);
    return {b, d, p, t, c};
  endfunction

  // Inputs change on the falling edge; outputs are read there too.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Two samples of resp=001 then finish; ends one edge after CHECK -> DONE.
  task automatic run_pass_a();
    pulse_start();
    valid = 1'b1; resp = 3'b001;
    step(2);
    valid = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    step();
  endtask

  task automatic test_reset();
    total++;
    if (obs_a !== 19'h0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs_a, 19'h0);
    end else $display("ok   reset_state");
    RST = 1'b1;
    valid = 1'b1; finish = 1'b1; resp = 3'b111;
    step(2);
    valid = 1'b0; finish = 1'b0; resp = 3'b000;
    total++;
    if (obs_a !== 19'h0) begin
      bad++; $display("FAIL idle_ignores got=%h want=%h", obs_a, 19'h0);
    end else $display("ok   idle_ignores");
  endtask

  task automatic test_basic();
    pulse_start();
    exp_v = pk(1, 0, 0, 0, 15'd0);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL run_entry got=%h want=%h", obs_a, exp_v);
    end else $display("ok   run_entry");
    valid = 1'b1; resp = 3'b001;
    step(2);
    valid = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    exp_v = pk(1, 0, 0, 0, 15'd2);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL check_latency got=%h want=%h", obs_a, exp_v);
    end else $display("ok   check_latency");
    step();
    exp_v = pk(0, 1, 1, 0, 15'd2);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL basic_pass got=%h want=%h", obs_a, exp_v);
    end else $display("ok   basic_pass");
    // u_b: 80 -> 1C -> 39, not 1D
    exp_v = pk(0, 1, 0, 0, 15'd2);
    total++;
    if (obs_b !== exp_v) begin
      bad++; $display("FAIL basic_b_fail got=%h want=%h", obs_b, exp_v);
    end else $display("ok   basic_b_fail");
  endtask

  task automatic test_poly();
    // 80 shifted with no response: MSB feedback gives 1D
    pulse_start();
    valid = 1'b1; resp = 3'b000;
    step();
    valid = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    exp_v = pk(0, 1, 1, 0, 15'd1);
    total++;
    if (obs_b !== exp_v) begin
      bad++; $display("FAIL poly_pass got=%h want=%h", obs_b, exp_v);
    end else $display("ok   poly_pass");
    // resp=010 with finish in the same cycle: sample compacted first -> 1F
    pulse_start();
    valid = 1'b1; resp = 3'b010; finish = 1'b1;
    step();
    valid = 1'b0; finish = 1'b0; resp = 3'b000;
    step();
    exp_v = pk(0, 1, 0, 0, 15'd1);
    total++;
    if (obs_b !== exp_v) begin
      bad++; $display("FAIL poly_fail_same_cycle got=%h want=%h", obs_b, exp_v);
    end else $display("ok   poly_fail_same_cycle");
  endtask

  task automatic test_no_valid();
    pulse_start();
    step(5);
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    exp_v = pk(0, 1, 0, 0, 15'd0);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL novalid_a got=%h want=%h", obs_a, exp_v);
    end else $display("ok   novalid_a");
    total++;
    if (obs_b !== exp_v) begin
      bad++; $display("FAIL novalid_b got=%h want=%h", obs_b, exp_v);
    end else $display("ok   novalid_b");
  endtask

  task automatic test_watchdog();
    pulse_start();
    valid = 1'b1; resp = 3'b001;
    step(9);
    exp_v = pk(1, 0, 0, 0, 15'd9);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL wd_before got=%h want=%h", obs_a, exp_v);
    end else $display("ok   wd_before");
    step();
    exp_v = pk(0, 1, 0, 1, 15'd10);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL wd_expire got=%h want=%h", obs_a, exp_v);
    end else $display("ok   wd_expire");
    finish = 1'b1;
    step(2);
    valid = 1'b0; finish = 1'b0;
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL wd_hold got=%h want=%h", obs_a, exp_v);
    end else $display("ok   wd_hold");
  endtask

  task automatic test_wd_finish();
    // finish on the 10th sample beats the watchdog; sig D8 != 03
    pulse_start();
    valid = 1'b1; resp = 3'b001;
    step(9);
    finish = 1'b1;
    step();
    valid = 1'b0; finish = 1'b0;
    step();
    exp_v = pk(0, 1, 0, 0, 15'd10);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL wd_finish_wins got=%h want=%h", obs_a, exp_v);
    end else $display("ok   wd_finish_wins");
  endtask

  task automatic test_restart();
    pulse_start();
    valid = 1'b1; resp = 3'b001;
    step(3);
    exp_v = pk(1, 0, 0, 0, 15'd3);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL restart_pre got=%h want=%h", obs_a, exp_v);
    end else $display("ok   restart_pre");
    start = 1'b1; finish = 1'b1;
    step();
    start = 1'b0; finish = 1'b0;
    exp_v = pk(1, 0, 0, 0, 15'd0);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL restart_clear got=%h want=%h", obs_a, exp_v);
    end else $display("ok   restart_clear");
    // pass only if the signature really was re-seeded
    step(2);
    valid = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    exp_v = pk(0, 1, 1, 0, 15'd2);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL restart_verdict got=%h want=%h", obs_a, exp_v);
    end else $display("ok   restart_verdict");
    // asynchronous reset in the middle of a run
    pulse_start();
    valid = 1'b1;
    step(2);
    #2 RST = 1'b0;
    #1;
    total++;
    if (obs_a !== 19'h0 || obs_b !== 19'h0) begin
      bad++; $display("FAIL async_reset got=%h/%h want=0", obs_a, obs_b);
    end else $display("ok   async_reset");
    @(negedge CLK);
    RST = 1'b1; valid = 1'b0;
    step();
    total++;
    if (obs_a !== 19'h0) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", obs_a, 19'h0);
    end else $display("ok   reset_idle");
  endtask

  task automatic test_done_hold();
    run_pass_a();
    valid = 1'b1; resp = 3'b111; finish = 1'b1;
    step(2);
    valid = 1'b0; finish = 1'b0; resp = 3'b000;
    exp_v = pk(0, 1, 1, 0, 15'd2);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL done_hold got=%h want=%h", obs_a, exp_v);
    end else $display("ok   done_hold");
    pulse_start();
    exp_v = pk(1, 0, 0, 0, 15'd0);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL rearm got=%h want=%h", obs_a, exp_v);
    end else $display("ok   rearm");
    valid = 1'b1; resp = 3'b001;
    step();
    valid = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    exp_v = pk(0, 1, 0, 0, 15'd1);
    total++;
    if (obs_a !== exp_v) begin
      bad++; $display("FAIL rearm_run got=%h want=%h", obs_a, exp_v);
    end else $display("ok   rearm_run");
  endtask

`ifdef BIST_SIG_READOUT_EN
  task automatic test_readout();
    run_pass_a();
    total++;
    if (a_sig !== 8'h03) begin
      bad++; $display("FAIL readout_sig got=%h want=%h", a_sig, 8'h03);
    end else $display("ok   readout_sig");
    sig_shift = 1'b1;
    step();
    total++;
    if (a_sig !== 8'h06 || a_pass !== 1'b1) begin
      bad++; $display("FAIL readout_rot1 got=%h/%b want=06/1", a_sig, a_pass);
    end else $display("ok   readout_rot1");
    step(7);
    sig_shift = 1'b0;
    total++;
    if (a_sig !== 8'h03) begin
      bad++; $display("FAIL readout_rot8 got=%h want=%h", a_sig, 8'h03);
    end else $display("ok   readout_rot8");
  endtask
`endif

  initial begin
    RST = 1'b0; start = 1'b0; valid = 1'b0; finish = 1'b0; resp = 3'b000;
`ifdef BIST_SIG_READOUT_EN
    sig_shift = 1'b0;
`endif
    step(2);
    test_reset();
    test_basic();
    test_poly();
    test_no_valid();
    test_watchdog();
    test_wd_finish();
    test_restart();
    test_done_hold();
`ifdef BIST_SIG_READOUT_EN
    test_readout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
